// File: rtl/em_pkg.sv
// rtl/em_pkg.sv - shared types and constants for the electromagnet task sequencer
package em_pkg;

  localparam int NODE_W = 5;
  localparam logic [NODE_W-1:0] IDLE_NODE = 5'd31;

  // Nodes on which the electromagnet driver latches the magnet
  localparam int N_LATCH = 4;
  localparam logic [N_LATCH*NODE_W-1:0] LATCH_NODES = {5'd23, 5'd22, 5'd11, 5'd10};

  typedef enum logic [2:0] {
    IDLE,
    SEEK_PICK,
    CONFIRM,
    CARRY,
    RELEASE,
    FAULT
  } state_t;

  function automatic logic is_latch_node(input logic [NODE_W-1:0] n);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_LATCH; i++) begin
      if (LATCH_NODES[i*NODE_W +: NODE_W] == n) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/dist_confirm.sv
// rtl/dist_confirm.sv - consecutive near-sample counter for block presence
module dist_confirm #(
  parameter int DIST_W    = 9,
  parameter int NEAR_CM   = 10,
  parameter int CONFIRM_N = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              dist_valid,
  input  logic [DIST_W-1:0] dist_cm,
  output logic              confirmed
);

  localparam int CNT_W = $clog2(CONFIRM_N + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (dist_valid) begin
      if (dist_cm <= DIST_W'(NEAR_CM)) begin
        if (cnt_q != CNT_W'(CONFIRM_N)) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Looks at the post-sample count so the sequencer can act on the same edge
  assign confirmed = (cnt_d == CNT_W'(CONFIRM_N));

endmodule

// File: rtl/em_task_sequencer.sv
// rtl/em_task_sequencer.sv - pick/drop task sequencer feeding the electromagnet driver
module em_task_sequencer #(
  parameter int                        NODE_W         = em_pkg::NODE_W,
  parameter int                        DIST_W         = 9,
  parameter int                        NEAR_CM        = 10,
  parameter int                        CONFIRM_N      = 4,
  parameter int                        TIMEOUT_CYCLES = 50_000_000,
  parameter int                        DELATCH_CYCLES = 25_000_000,
  parameter logic [NODE_W-1:0]         IDLE_NODE      = em_pkg::IDLE_NODE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              task_valid,
  output logic              task_ready,
  input  logic [NODE_W-1:0] pick_node,
  input  logic [NODE_W-1:0] drop_node,
  input  logic              node_valid,
  input  logic [NODE_W-1:0] node_id,
  input  logic              dist_valid,
  input  logic [DIST_W-1:0] dist_cm,
  output logic [NODE_W-1:0] future_node,
  output logic              delatch,
  output logic              busy,
  output logic              done,
  output logic              fault
);

  import em_pkg::*;

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int DL_W  = (DELATCH_CYCLES > 1) ? $clog2(DELATCH_CYCLES) : 1;

  state_t            state_q, state_d;
  logic [NODE_W-1:0] pick_q, pick_d;
  logic [NODE_W-1:0] drop_q, drop_d;
  logic [NODE_W-1:0] fnode_d;
  logic              delatch_d, done_d, fault_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [DL_W-1:0]   dl_q, dl_d;
  logic              handshake;
  logic              confirmed;

  dist_confirm #(
    .DIST_W    (DIST_W),
    .NEAR_CM   (NEAR_CM),
    .CONFIRM_N (CONFIRM_N)
  ) u_dist_confirm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state_q != CONFIRM),
    .dist_valid (dist_valid),
    .dist_cm    (dist_cm),
    .confirmed  (confirmed)
  );

  assign handshake = task_valid & task_ready & en;

  always_comb begin
    state_d   = state_q;
    pick_d    = pick_q;
    drop_d    = drop_q;
    fnode_d   = future_node;
    delatch_d = delatch;
    done_d    = 1'b0;
    fault_d   = fault;
    tmo_d     = tmo_q;
    dl_d      = dl_q;

    case (state_q)
      IDLE, FAULT: begin
        if (handshake) begin
          pick_d  = pick_node;
          drop_d  = drop_node;
          fnode_d = IDLE_NODE;
          if (pick_node == drop_node) begin
            state_d   = FAULT;
            fault_d   = 1'b1;
            delatch_d = 1'b1;
          end else begin
            state_d   = SEEK_PICK;
            fault_d   = 1'b0;
            delatch_d = 1'b0;
          end
        end
      end

      SEEK_PICK: begin
        if (!en) begin
          state_d = IDLE;
        end else if (node_valid && node_id == pick_q) begin
          state_d = CONFIRM;
          tmo_d   = '0;
        end
      end

      CONFIRM: begin
        // A confirmation on the final timeout cycle still counts
        if (!en) begin
          state_d = IDLE;
        end else if (confirmed) begin
          state_d = CARRY;
          fnode_d = pick_q;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = FAULT;
          fault_d   = 1'b1;
          delatch_d = 1'b1;
          fnode_d   = IDLE_NODE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      CARRY: begin
        // Losing enable while carrying still drops the block safely
        if (!en || (node_valid && node_id == drop_q)) begin
          state_d   = RELEASE;
          delatch_d = 1'b1;
          dl_d      = '0;
        end
      end

      RELEASE: begin
        if (dl_q == DL_W'(DELATCH_CYCLES - 1)) begin
          state_d   = IDLE;
          delatch_d = 1'b0;
          fnode_d   = IDLE_NODE;
          done_d    = 1'b1;
        end else begin
          dl_d = dl_q + DL_W'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        delatch_d = 1'b0;
        fnode_d   = IDLE_NODE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pick_q      <= '0;
      drop_q      <= '0;
      future_node <= IDLE_NODE;
      delatch     <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      task_ready  <= 1'b1;
      busy        <= 1'b0;
      tmo_q       <= '0;
      dl_q        <= '0;
    end else begin
      state_q     <= state_d;
      pick_q      <= pick_d;
      drop_q      <= drop_d;
      future_node <= fnode_d;
      delatch     <= delatch_d;
      done        <= done_d;
      fault       <= fault_d;
      task_ready  <= (state_d == IDLE) || (state_d == FAULT);
      busy        <= (state_d != IDLE);
      tmo_q       <= tmo_d;
      dl_q        <= dl_d;
    end
  end

endmodule

// File: tb/tb_em_task_sequencer.sv
// tb/tb_em_task_sequencer.sv - scoreboard bench for em_task_sequencer
module tb_em_task_sequencer;

  localparam int TO = 100;
  localparam int DL = 8;
  localparam int CN = 4;

  logic       clk = 1'b0;
  logic       rst_n, en, task_valid, node_valid, dist_valid;
  logic [4:0] pick_node, drop_node, node_id;
  logic [8:0] dist_cm;
  logic       task_ready, delatch, busy, done, fault;
  logic [4:0] future_node;

  em_task_sequencer #(
    .NODE_W(5), .DIST_W(9), .NEAR_CM(10), .CONFIRM_N(CN),
    .TIMEOUT_CYCLES(TO), .DELATCH_CYCLES(DL), .IDLE_NODE(5'd31)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .task_valid(task_valid), .task_ready(task_ready),
    .pick_node(pick_node), .drop_node(drop_node),
    .node_valid(node_valid), .node_id(node_id),
    .dist_valid(dist_valid), .dist_cm(dist_cm),
    .future_node(future_node), .delatch(delatch),
    .busy(busy), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  // Snapshot layout: {done, fault, delatch, busy, task_ready, future_node}
  typedef struct {
    logic [9:0] s;
    int         at;
    string      name;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [9:0] prev = 'x;
  logic [9:0] cur;

  always @(posedge clk) cyc <= cyc + 1;

  // Every change of the output snapshot is an event that must match the queue head
  always @(negedge clk) begin
    exp_t e;
    cur = {done, fault, delatch, busy, task_ready, future_node};
    if (cur !== prev) begin
      prev = cur;
      n_checks++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_event: got %b at cycle %0d, required no change", cur, cyc);
      end else begin
        e = q.pop_front();
        if (cur === e.s && (e.at < 0 || e.at == cyc)) n_pass++;
        else $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d",
                      e.name, cur, cyc, e.s, e.at);
      end
    end
  end

  function automatic void expect_ev(input string name, input logic d, input logic f,
                                    input logic dl, input logic b, input logic r,
                                    input logic [4:0] fn, input int at);
    exp_t e;
    e.s = {d, f, dl, b, r, fn};
    e.at = at;
    e.name = name;
    q.push_back(e);
  endfunction

  task automatic chk(input string name, input int got, input int req);
    n_checks++;
    if (got == req) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, got, req);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic offer(input logic [4:0] p, input logic [4:0] d);
    task_valid = 1'b1; pick_node = p; drop_node = d;
    tick();
    task_valid = 1'b0;
  endtask

  task automatic node(input logic [4:0] id);
    node_valid = 1'b1; node_id = id;
    tick();
    node_valid = 1'b0;
  endtask

  task automatic sample(input logic [8:0] cm);
    dist_valid = 1'b1; dist_cm = cm;
    tick();
    dist_valid = 1'b0;
  endtask

  int t0, tc;
  int broken [8] = '{6, 6, 6, 40, 6, 6, 6, 6};

  initial begin
    rst_n = 1'b0; en = 1'b1; task_valid = 1'b0; node_valid = 1'b0; dist_valid = 1'b0;
    pick_node = '0; drop_node = '0; node_id = '0; dist_cm = '0;
    expect_ev("reset_state", 0, 0, 0, 0, 1, 5'd31, -1);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Nominal pick at 10, drop at 3
    expect_ev("accept_nominal", 0, 0, 0, 1, 0, 5'd31, cyc + 1);
    offer(5'd10, 5'd3);
    node(5'd5);
    node(5'd10);
    sample(9'd6); sample(9'd6); sample(9'd6);
    expect_ev("latch_nominal", 0, 0, 0, 1, 0, 5'd10, cyc + 1);
    sample(9'd6);
    node(5'd7);
    tick(2);
    t0 = cyc + 1;
    expect_ev("release_nominal", 0, 0, 1, 1, 0, 5'd10, t0);
    expect_ev("done_nominal", 1, 0, 0, 0, 1, 5'd31, t0 + DL);
    expect_ev("done_clear_nominal", 0, 0, 0, 0, 1, 5'd31, t0 + DL + 1);
    node(5'd3);
    tick(DL + 3);

    // Near run broken by one far sample
    expect_ev("accept_broken", 0, 0, 0, 1, 0, 5'd31, cyc + 1);
    offer(5'd22, 5'd5);
    node(5'd22);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) expect_ev("latch_after_8th", 0, 0, 0, 1, 0, 5'd22, cyc + 1);
      sample(9'(broken[i]));
    end
    t0 = cyc + 1;
    expect_ev("release_broken", 0, 0, 1, 1, 0, 5'd22, t0);
    expect_ev("done_broken", 1, 0, 0, 0, 1, 5'd31, t0 + DL);
    expect_ev("done_clear_broken", 0, 0, 0, 0, 1, 5'd31, t0 + DL + 1);
    node(5'd5);
    tick(DL + 3);

    // Timeout at 11: 11 cm is just outside the near threshold
    expect_ev("accept_timeout", 0, 0, 0, 1, 0, 5'd31, cyc + 1);
    offer(5'd11, 5'd4);
    node(5'd11);
    tc = cyc;
    expect_ev("timeout_fault", 0, 1, 1, 1, 1, 5'd31, tc + TO);
    tick(5);
    sample(9'd40); sample(9'd6); sample(9'd6); sample(9'd6); sample(9'd200);
    sample(9'd11); sample(9'd11); sample(9'd11); sample(9'd11);
    tick(tc + TO + 2 - cyc);
    expect_ev("fault_cleared", 0, 0, 0, 1, 0, 5'd31, cyc + 1);
    offer(5'd10, 5'd23);
    tick(2);
    expect_ev("en_drop_seek", 0, 0, 0, 0, 1, 5'd31, cyc + 1);
    en = 1'b0;
    tick();
    en = 1'b1;
    tick(3);

    // Identical pick and drop goes straight to FAULT
    expect_ev("invalid_fault", 0, 1, 1, 1, 1, 5'd31, cyc + 1);
    offer(5'd23, 5'd23);
    tick(3);
    expect_ev("accept_from_fault", 0, 0, 0, 1, 0, 5'd31, cyc + 1);
    offer(5'd23, 5'd10);
    node(5'd23);
    sample(9'd6); sample(9'd6); sample(9'd6);
    expect_ev("latch_23", 0, 0, 0, 1, 0, 5'd23, cyc + 1);
    sample(9'd6);
    tick(2);
    t0 = cyc + 1;
    expect_ev("en_drop_release", 0, 0, 1, 1, 0, 5'd23, t0);
    expect_ev("done_en_drop", 1, 0, 0, 0, 1, 5'd31, t0 + DL);
    expect_ev("done_clear_en_drop", 0, 0, 0, 0, 1, 5'd31, t0 + DL + 1);
    en = 1'b0;
    tick(DL + 3);
    en = 1'b1;

    // Fourth near sample lands on the last timeout cycle: confirmation wins
    expect_ev("accept_race", 0, 0, 0, 1, 0, 5'd31, cyc + 1);
    offer(5'd10, 5'd22);
    node(5'd10);
    tc = cyc;
    tick(10);
    sample(9'd40);
    tick(tc + TO - 4 - cyc);
    sample(9'd10); sample(9'd10); sample(9'd10);
    expect_ev("latch_race", 0, 0, 0, 1, 0, 5'd10, tc + TO);
    sample(9'd10);
    tick(3);
    t0 = cyc + 1;
    expect_ev("release_race", 0, 0, 1, 1, 0, 5'd10, t0);
    expect_ev("done_race", 1, 0, 0, 0, 1, 5'd31, t0 + DL);
    expect_ev("done_clear_race", 0, 0, 0, 0, 1, 5'd31, t0 + DL + 1);
    node(5'd22);
    tick(DL + 3);

    // Asynchronous reset in the middle of RELEASE
    expect_ev("accept_reset", 0, 0, 0, 1, 0, 5'd31, cyc + 1);
    offer(5'd11, 5'd2);
    node(5'd11);
    sample(9'd6); sample(9'd6); sample(9'd6);
    expect_ev("latch_reset", 0, 0, 0, 1, 0, 5'd11, cyc + 1);
    sample(9'd6);
    expect_ev("release_reset", 0, 0, 1, 1, 0, 5'd11, cyc + 1);
    node(5'd2);
    tick(3);
    #2;
    expect_ev("reset_async_event", 0, 0, 0, 0, 1, 5'd31, cyc);
    rst_n = 1'b0;
    #1;
    chk("reset_delatch", int'(delatch), 0);
    chk("reset_future_node", int'(future_node), 31);
    chk("reset_busy", int'(busy), 0);
    chk("reset_task_ready", int'(task_ready), 1);
    tick(2);
    rst_n = 1'b1;
    tick(4);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      $display("FAIL %s: got no event, required %b at cycle %0d", e.name, e.s, e.at);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
